// File: rtl/stack_ctrl.sv
// Downward-growing hardware stack controller: serialises push/pop requests onto a
// handshaked single-port data memory and tracks the stack pointer, depth and error flags.
module stack_ctrl #(
  parameter logic [15:0] STACK_BASE = 16'h03FF,
  parameter int          DEPTH      = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        push_req,
  input  logic        pop_req,
  input  logic [15:0] push_data,
  output logic [15:0] pop_out,
  output logic        push_done,
  output logic        pop_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] sp,
  output logic [10:0] count,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam logic [10:0] DEPTH_C = 11'(DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, DONE} state_t;

  state_t state;
  logic   op_push;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= IDLE;
      op_push   <= 1'b0;
      sp        <= STACK_BASE;
      count     <= '0;
      pop_out   <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      case (state)
        IDLE: begin
          // The done pulse lands in this state; requesters are still releasing
          // their level request during it, so nothing is accepted then.
          if (!push_done && !pop_done) begin
            if (push_req) begin
              op_push <= 1'b1;
              if (count < DEPTH_C) begin
                state     <= PUSH_WR;
                mem_we    <= 1'b1;
                mem_addr  <= sp;
                mem_wdata <= push_data;
              end else begin
                stk_ovf <= 1'b1;
                state   <= DONE;
              end
            end else if (pop_req) begin
              op_push <= 1'b0;
              if (count != 11'd0) begin
                state    <= POP_RD;
                mem_re   <= 1'b1;
                mem_addr <= sp + 16'd1;
              end else begin
                stk_unf <= 1'b1;
                state   <= DONE;
              end
            end
          end
        end
        PUSH_WR: begin
          if (mem_ack) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            sp        <= sp - 16'd1;
            count     <= count + 11'd1;
            state     <= DONE;
          end
        end
        POP_RD: begin
          if (mem_ack) begin
            mem_re   <= 1'b0;
            mem_addr <= '0;
            pop_out  <= mem_rdata;
            sp       <= sp + 16'd1;
            count    <= count - 11'd1;
            state    <= DONE;
          end
        end
        DONE: begin
          push_done <= op_push;
          pop_done  <= !op_push;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
